rmap_status_ctrl: RTL and testbench

- Control/status register block wrapped around the RMAP target.
- Drives the target's authentication config (configKey, logicalAddress).
- Edge-detects the target's status indications, counts them in saturating counters, keeps sticky error flags and the last error code, and raises a maskable interrupt.
- Accessed by the host through a simple req/ack register port.

---
 rtl/rmap_status_pkg.sv | 43 ++++
 rtl/rmap_status_ctrl_if.sv | 28 ++
 rtl/rmap_errlog_fifo.sv | 66 ++++++
 rtl/rmap_status_ctrl.sv | 241 ++++++++++++++++++++++++
 tb/tb_rmap_status_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rmap_status_pkg.sv
// Shared definitions for the RMAP target status/control block: register map,
// STATUS bit layout, handshake FSM encoding and the indication bundle type.
// Optional feature macro used by the block: RMAP_STATUS_ERRLOG_EN.
package rmap_status_pkg;

  localparam int unsigned REG_ADDR_W = 3;
  localparam int unsigned REG_DATA_W = 32;
  localparam int unsigned DEF_CNT_W  = 16;
  localparam int unsigned NUM_CNT    = 4;

  // Register indices
  localparam logic [REG_ADDR_W-1:0] REG_CONFIG  = 3'd0;
  localparam logic [REG_ADDR_W-1:0] REG_STATUS  = 3'd1;
  localparam logic [REG_ADDR_W-1:0] REG_WRCNT   = 3'd2;
  localparam logic [REG_ADDR_W-1:0] REG_RDCNT   = 3'd3;
  localparam logic [REG_ADDR_W-1:0] REG_RMWCNT  = 3'd4;
  localparam logic [REG_ADDR_W-1:0] REG_ERRCNT  = 3'd5;
  localparam logic [REG_ADDR_W-1:0] REG_ERRLOG  = 3'd6;
  localparam logic [REG_ADDR_W-1:0] REG_IRQMASK = 3'd7;

  // STATUS bit positions (bits [3:0] are W1C, lastCode sits at [15:8])
  localparam int unsigned STAT_ERR_SEEN = 0;
  localparam int unsigned STAT_ADDR_INV = 1;
  localparam int unsigned STAT_LEN_INV  = 2;
  localparam int unsigned STAT_LOG_OVF  = 3;
  localparam int unsigned STAT_CODE_LSB = 8;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } reg_state_t;

  // One bit per target indication, sampled together
  typedef struct packed {
    logic err;
    logic wr;
    logic rd;
    logic rmw;
    logic addrInv;
    logic lenInv;
  } ind_t;

endpackage

// File: rtl/rmap_status_ctrl_if.sv
// Host register port of rmap_status_ctrl.
//   regReq   : access request, 1-cycle pulse
//   regWe    : 1 = write, 0 = read, sampled with regReq
//   regAddr  : register index
//   regWdata : write data
//   regRdata : read data, valid while regAck = 1
//   regAck   : access-complete pulse
interface rmap_status_ctrl_if;
  import rmap_status_pkg::*;

  logic                  regReq;
  logic                  regWe;
  logic [REG_ADDR_W-1:0] regAddr;
  logic [REG_DATA_W-1:0] regWdata;
  logic [REG_DATA_W-1:0] regRdata;
  logic                  regAck;

  modport master (
    output regReq, regWe, regAddr, regWdata,
    input  regRdata, regAck
  );

  modport slave (
    input  regReq, regWe, regAddr, regWdata,
    output regRdata, regAck
  );

endinterface

// File: rtl/rmap_errlog_fifo.sv
// Synchronous DEPTH x W FIFO holding target error codes.
//   push/pushData : enqueue (ignored when full unless a pop happens too)
//   pop           : dequeue (ignored when empty)
//   headData_c    : oldest entry, combinational
//   full_c/empty_c: occupancy flags, combinational
// DEPTH must be a power of two and at least 2.
module rmap_errlog_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] pushData,
  input  logic         pop,
  output logic [W-1:0] headData_c,
  output logic         full_c,
  output logic         empty_c
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic [CW-1:0] count;
  logic          doPush;
  logic          doPop;

  assign full_c     = (count == CW'(DEPTH));
  assign empty_c    = (count == '0);
  assign doPop      = pop && !empty_c;
  // A simultaneous pop frees a slot, so a push into a full FIFO still lands
  assign doPush     = push && (!full_c || doPop);
  assign headData_c = mem[rdPtr];

  // Storage needs no reset; count/pointers qualify its contents
  always_ff @(posedge clk) begin
    if (doPush) begin
      mem[wrPtr] <= pushData;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) begin
        wrPtr <= wrPtr + AW'(1);
      end
      if (doPop) begin
        rdPtr <= rdPtr + AW'(1);
      end
      case ({doPush, doPop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rmap_status_ctrl.sv
// Control/status register block around the RMAP target.
// Drives the target's authentication config, edge-detects its status
// indications into saturating counters and sticky flags, records the last
// error code and raises a maskable level interrupt.
// Optional error-code log FIFO on register 6: define RMAP_STATUS_ERRLOG_EN.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   rmapErrorCode         : target error code, valid when errorIndication rises
//   errorIndication       : target error indication (level)
//   writeDataIndication   : write completed
//   readDataIndication    : read completed
//   rmwDataIndication     : read-modify-write completed
//   addrInvalid           : authentication address invalid
//   dataLengthInvalid     : authentication data length invalid
//   configKey             : key to target
//   logicalAddress        : target logical address
//   regBus                : host register port (slave side)
//   irq                   : level interrupt
module rmap_status_ctrl
  import rmap_status_pkg::*;
#(
  parameter int unsigned CNT_W        = DEF_CNT_W,
  parameter logic [7:0]  DEF_KEY      = 8'h20,
  parameter logic [7:0]  DEF_LADDR    = 8'hFE,
  parameter int unsigned ERRLOG_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          rmapErrorCode,
  input  logic                errorIndication,
  input  logic                writeDataIndication,
  input  logic                readDataIndication,
  input  logic                rmwDataIndication,
  input  logic                addrInvalid,
  input  logic                dataLengthInvalid,
  output logic [7:0]          configKey,
  output logic [7:0]          logicalAddress,
  rmap_status_ctrl_if.slave   regBus,
  output logic                irq
);

  if (CNT_W < 8 || CNT_W > 32) begin : g_bad_cnt_w
    $error("rmap_status_ctrl: CNT_W must be within 8..32");
  end
  if (ERRLOG_DEPTH < 2 || (ERRLOG_DEPTH & (ERRLOG_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("rmap_status_ctrl: ERRLOG_DEPTH must be a power of two >= 2");
  end

  localparam logic [0:0] S_IDLE = 1'(ST_IDLE);
  localparam logic [0:0] S_ACK  = 1'(ST_ACK);

  logic [0:0]                     state;
  logic [0:0]                     stateNext;
  logic                           accept;
  logic                           wrAcc;
  logic                           rdAcc;

  ind_t                           indR;
  ind_t                           indQ;
  ind_t                           indEdge;
  logic [7:0]                     codeR;

  logic [NUM_CNT-1:0][CNT_W-1:0]  cnt;
  logic [NUM_CNT-1:0][CNT_W-1:0]  cntNext;
  logic [NUM_CNT-1:0]             cntEv;
  logic [NUM_CNT-1:0]             cntClr;

  logic [3:0]                     sticky;
  logic [3:0]                     stickySet;
  logic [3:0]                     stickyClr;
  logic [3:0]                     stickyNext;
  logic [3:0]                     irqMask;
  logic [3:0]                     maskNext;
  logic [7:0]                     lastCode;

  logic                           wrConfig;
  logic                           wrStatus;
  logic                           wrMask;
  logic                           logOvfSet;
  logic [REG_DATA_W-1:0]          logRead;
  logic [REG_DATA_W-1:0]          rdMux;
  logic [REG_DATA_W-1:0]          rdataQ;
  logic                           ackQ;
  logic                           unusedWdata;

  assign regBus.regRdata = rdataQ;
  assign regBus.regAck   = ackQ;
  assign unusedWdata     = ^regBus.regWdata[31:16];

  // Handshake FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Handshake FSM: next state; requests arriving in ACK are dropped
  always_comb begin
    stateNext = state;
    accept    = 1'b0;
    case (state)
      S_IDLE: begin
        if (regBus.regReq) begin
          accept    = 1'b1;
          stateNext = S_ACK;
        end
      end
      S_ACK:   stateNext = S_IDLE;
      default: stateNext = S_IDLE;
    endcase
  end

  assign wrAcc    = accept && regBus.regWe;
  assign rdAcc    = accept && !regBus.regWe;
  assign wrConfig = wrAcc && (regBus.regAddr == REG_CONFIG);
  assign wrStatus = wrAcc && (regBus.regAddr == REG_STATUS);
  assign wrMask   = wrAcc && (regBus.regAddr == REG_IRQMASK);

  // Indication sampling; history resets to 0 so a level high at release counts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      indR  <= '0;
      indQ  <= '0;
      codeR <= '0;
    end else begin
      indR  <= '{err: errorIndication, wr: writeDataIndication,
                 rd: readDataIndication, rmw: rmwDataIndication,
                 addrInv: addrInvalid, lenInv: dataLengthInvalid};
      indQ  <= indR;
      codeR <= rmapErrorCode;
    end
  end

  assign indEdge = ind_t'(indR & ~indQ);

  // Event log (optional)
`ifdef RMAP_STATUS_ERRLOG_EN
  logic       logPop;
  logic       logFull;
  logic       logEmpty;
  logic [7:0] logHead;

  assign logPop = rdAcc && (regBus.regAddr == REG_ERRLOG) && !logEmpty;

  rmap_errlog_fifo #(
    .DEPTH (ERRLOG_DEPTH),
    .W     (8)
  ) u_errlog (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (indEdge.err),
    .pushData   (codeR),
    .pop        (logPop),
    .headData_c (logHead),
    .full_c     (logFull),
    .empty_c    (logEmpty)
  );

  assign logOvfSet = indEdge.err && logFull && !logPop;
  assign logRead   = logEmpty ? '0 : {23'h0, 1'b1, logHead};
`else
  assign logOvfSet = 1'b0;
  assign logRead   = '0;
`endif

  // Counter next values: clear and a coincident event yield 1; saturate at all-ones
  assign cntEv = {indEdge.err, indEdge.rmw, indEdge.rd, indEdge.wr};

  always_comb begin
    cntClr  = '0;
    cntNext = cnt;
    for (int i = 0; i < int'(NUM_CNT); i++) begin
      cntClr[i] = wrAcc && (regBus.regAddr == (REG_WRCNT + 3'(i)));
      if (cntClr[i]) begin
        cntNext[i] = CNT_W'(cntEv[i]);
      end else if (cntEv[i] && (cnt[i] != '1)) begin
        cntNext[i] = cnt[i] + CNT_W'(1);
      end
    end
  end

  // Sticky flags: a new set beats a coincident W1C
  always_comb begin
    stickySet                = '0;
    stickySet[STAT_ERR_SEEN] = indEdge.err;
    stickySet[STAT_ADDR_INV] = indEdge.addrInv;
    stickySet[STAT_LEN_INV]  = indEdge.lenInv;
    stickySet[STAT_LOG_OVF]  = logOvfSet;
    stickyClr  = wrStatus ? regBus.regWdata[3:0] : '0;
    stickyNext = (sticky & ~stickyClr) | stickySet;
    maskNext   = wrMask ? regBus.regWdata[3:0] : irqMask;
  end

  // Read mux uses current values, so a read racing an event sees the old value
  always_comb begin
    rdMux = '0;
    case (regBus.regAddr)
      REG_CONFIG:  rdMux = {16'h0, logicalAddress, configKey};
      REG_STATUS:  rdMux = (32'(lastCode) << STAT_CODE_LSB) | 32'(sticky);
      REG_WRCNT:   rdMux = 32'(cnt[0]);
      REG_RDCNT:   rdMux = 32'(cnt[1]);
      REG_RMWCNT:  rdMux = 32'(cnt[2]);
      REG_ERRCNT:  rdMux = 32'(cnt[3]);
      REG_ERRLOG:  rdMux = logRead;
      REG_IRQMASK: rdMux = 32'(irqMask);
      default:     rdMux = '0;
    endcase
  end

  // Register state, counters, interrupt and host response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      configKey      <= DEF_KEY;
      logicalAddress <= DEF_LADDR;
      cnt            <= '0;
      sticky         <= '0;
      irqMask        <= '0;
      lastCode       <= '0;
      irq            <= 1'b0;
      ackQ           <= 1'b0;
      rdataQ         <= '0;
    end else begin
      if (wrConfig) begin
        configKey      <= regBus.regWdata[7:0];
        logicalAddress <= regBus.regWdata[15:8];
      end
      if (indEdge.err) begin
        lastCode <= codeR;
      end
      cnt     <= cntNext;
      sticky  <= stickyNext;
      irqMask <= maskNext;
      irq     <= |(stickyNext & maskNext);
      ackQ    <= accept;
      rdataQ  <= rdAcc ? rdMux : '0;
    end
  end

endmodule

// File: tb/tb_rmap_status_ctrl.sv
module tb_rmap_status_ctrl;
  import rmap_status_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [7:0] rmapErrorCode;
  logic       errorIndication;
  logic       writeDataIndication;
  logic       readDataIndication;
  logic       rmwDataIndication;
  logic       addrInvalid;
  logic       dataLengthInvalid;
  logic [7:0] configKey;
  logic [7:0] logicalAddress;
  logic       irq;
  logic [7:0] configKey8;
  logic [7:0] logicalAddress8;
  logic       irq8;
  int         checks;
  int         errors;

  rmap_status_ctrl_if bus ();
  rmap_status_ctrl_if bus8 ();

  rmap_status_ctrl dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .rmapErrorCode       (rmapErrorCode),
    .errorIndication     (errorIndication),
    .writeDataIndication (writeDataIndication),
    .readDataIndication  (readDataIndication),
    .rmwDataIndication   (rmwDataIndication),
    .addrInvalid         (addrInvalid),
    .dataLengthInvalid   (dataLengthInvalid),
    .configKey           (configKey),
    .logicalAddress      (logicalAddress),
    .regBus              (bus),
    .irq                 (irq)
  );

  rmap_status_ctrl #(.CNT_W(8)) dut8 (
    .clk                 (clk),
    .rst_n               (rst_n),
    .rmapErrorCode       (rmapErrorCode),
    .errorIndication     (errorIndication),
    .writeDataIndication (writeDataIndication),
    .readDataIndication  (readDataIndication),
    .rmwDataIndication   (rmwDataIndication),
    .addrInvalid         (addrInvalid),
    .dataLengthInvalid   (dataLengthInvalid),
    .configKey           (configKey8),
    .logicalAddress      (logicalAddress8),
    .regBus              (bus8),
    .irq                 (irq8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One register access; optionally fires an error edge timed to land on the access cycle
  task automatic regAccess(input bit sel8, input bit preErr, input logic [7:0] code,
                           input logic we, input logic [2:0] addr,
                           input logic [31:0] wdata, output logic [31:0] rdata);
    int lat;
    if (preErr) begin
      @(negedge clk);
      errorIndication = 1'b1;
      rmapErrorCode   = code;
    end
    @(negedge clk);
    if (preErr) errorIndication = 1'b0;
    if (sel8) begin
      bus8.regReq = 1'b1; bus8.regWe = we; bus8.regAddr = addr; bus8.regWdata = wdata;
    end else begin
      bus.regReq = 1'b1; bus.regWe = we; bus.regAddr = addr; bus.regWdata = wdata;
    end
    @(negedge clk);
    bus.regReq  = 1'b0;
    bus8.regReq = 1'b0;
    lat = 0;
    while (!(sel8 ? bus8.regAck : bus.regAck) && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    chk("ack_latency", 32'(lat), 32'd0);
    rdata = sel8 ? bus8.regRdata : bus.regRdata;
  endtask

  task automatic rd(input logic [2:0] addr, input logic [31:0] exp, input string tag);
    logic [31:0] v;
    regAccess(1'b0, 1'b0, 8'h00, 1'b0, addr, 32'h0, v);
    chk(tag, v, exp);
  endtask

  task automatic rd8(input logic [2:0] addr, input logic [31:0] exp, input string tag);
    logic [31:0] v;
    regAccess(1'b1, 1'b0, 8'h00, 1'b0, addr, 32'h0, v);
    chk(tag, v, exp);
  endtask

  task automatic wr(input logic [2:0] addr, input logic [31:0] data);
    logic [31:0] v;
    regAccess(1'b0, 1'b0, 8'h00, 1'b1, addr, data, v);
  endtask

  task automatic wr8(input logic [2:0] addr, input logic [31:0] data);
    logic [31:0] v;
    regAccess(1'b1, 1'b0, 8'h00, 1'b1, addr, data, v);
  endtask

  task automatic setInd(input int which, input logic v);
    case (which)
      0:       writeDataIndication = v;
      1:       readDataIndication  = v;
      2:       rmwDataIndication   = v;
      3:       addrInvalid         = v;
      4:       dataLengthInvalid   = v;
      default: errorIndication     = v;
    endcase
  endtask

  task automatic pulse(input int which, input int hi);
    @(negedge clk);
    setInd(which, 1'b1);
    repeat (hi) @(negedge clk);
    setInd(which, 1'b0);
  endtask

  task automatic pulseErr(input logic [7:0] code);
    @(negedge clk);
    rmapErrorCode   = code;
    errorIndication = 1'b1;
    @(negedge clk);
    errorIndication = 1'b0;
  endtask

  initial begin
    logic [31:0] rdv;
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    rmapErrorCode = 8'h00;
    errorIndication = 1'b0; writeDataIndication = 1'b0; readDataIndication = 1'b0;
    rmwDataIndication = 1'b0; addrInvalid = 1'b0; dataLengthInvalid = 1'b0;
    bus.regReq = 1'b0;  bus.regWe = 1'b0;  bus.regAddr = 3'd0;  bus.regWdata = 32'h0;
    bus8.regReq = 1'b0; bus8.regWe = 1'b0; bus8.regAddr = 3'd0; bus8.regWdata = 32'h0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_configKey", 32'(configKey), 32'h20);
    chk("rst_logicalAddress", 32'(logicalAddress), 32'hFE);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_regAck", 32'(bus.regAck), 32'd0);
    chk("rst_regRdata", bus.regRdata, 32'h0);
    chk("rst_configKey8", 32'(configKey8), 32'h20);
    chk("rst_irq8", 32'(irq8), 32'd0);
    rst_n = 1'b1;

    // CONFIG read, ack drops after one cycle, write and readback
    rd(REG_CONFIG, 32'h0000_FE20, "config_reset_read");
    @(negedge clk);
    chk("ack_one_cycle", 32'(bus.regAck), 32'd0);
    chk("rdata_back_to_zero", bus.regRdata, 32'h0);
    wr(REG_CONFIG, 32'h0000_4255);
    chk("configKey_written", 32'(configKey), 32'h55);
    chk("logicalAddress_written", 32'(logicalAddress), 32'h42);
    chk("logicalAddress8_untouched", 32'(logicalAddress8), 32'hFE);
    rd(REG_CONFIG, 32'h0000_4255, "config_readback");

    // Edge counting: 3 pulses + one held 5 cycles
    repeat (3) pulse(0, 1);
    pulse(0, 5);
    repeat (2) pulse(1, 1);
    pulse(2, 1);
    pulse(2, 2);
    repeat (3) @(negedge clk);
    rd(REG_WRCNT, 32'd4, "wrcnt_4");
    rd(REG_RDCNT, 32'd2, "rdcnt_2");
    rd(REG_RMWCNT, 32'd2, "rmwcnt_2");
    rd(REG_ERRCNT, 32'd0, "errcnt_0");

    // 300 more pulses: 16-bit reaches 304, 8-bit saturates at 255
    repeat (300) pulse(0, 1);
    repeat (3) @(negedge clk);
    rd(REG_WRCNT, 32'd304, "wrcnt_304");
    rd8(REG_WRCNT, 32'd255, "wrcnt8_saturated");
    wr8(REG_WRCNT, 32'h0);
    rd8(REG_WRCNT, 32'd0, "wrcnt8_cleared");
    wr(REG_WRCNT, 32'hFFFF_FFFF);
    rd(REG_WRCNT, 32'd0, "wrcnt_cleared");

    // Masked interrupt on an error edge
    wr(REG_IRQMASK, 32'h1);
    @(negedge clk);
    rmapErrorCode   = 8'h0A;
    errorIndication = 1'b1;
    @(negedge clk);
    errorIndication = 1'b0;
    chk("irq_not_yet", 32'(irq), 32'd0);
    @(negedge clk);
    chk("irq_set", 32'(irq), 32'd1);
    rd(REG_STATUS, 32'h0000_0A01, "status_err");
    rd(REG_ERRCNT, 32'd1, "errcnt_1");
    wr(REG_STATUS, 32'h1);
    chk("irq_cleared_w1c", 32'(irq), 32'd0);
    rd(REG_STATUS, 32'h0000_0A00, "status_after_w1c");

    // W1C coincident with a new set: flag stays set
    regAccess(1'b0, 1'b1, 8'h33, 1'b1, REG_STATUS, 32'h1, rdv);
    rd(REG_STATUS, 32'h0000_3301, "status_set_wins");
    chk("irq_set_wins", 32'(irq), 32'd1);

    // Counter clear coincident with an event gives 1
    regAccess(1'b0, 1'b1, 8'h44, 1'b1, REG_ERRCNT, 32'h0, rdv);
    rd(REG_ERRCNT, 32'd1, "errcnt_clear_vs_event");

    // Read coincident with an event returns the old count
    regAccess(1'b0, 1'b1, 8'h55, 1'b0, REG_ERRCNT, 32'h0, rdv);
    chk("errcnt_read_pre_update", rdv, 32'd1);
    rd(REG_ERRCNT, 32'd2, "errcnt_after_race");

    // Request during ACK is dropped
    @(negedge clk);
    bus.regReq = 1'b1; bus.regWe = 1'b0; bus.regAddr = REG_CONFIG; bus.regWdata = 32'h0;
    @(negedge clk);
    chk("ack_first", 32'(bus.regAck), 32'd1);
    chk("ack_first_rdata", bus.regRdata, 32'h0000_4255);
    bus.regWe = 1'b1; bus.regAddr = REG_IRQMASK; bus.regWdata = 32'hF;
    @(negedge clk);
    bus.regReq = 1'b0;
    chk("no_second_ack", 32'(bus.regAck), 32'd0);
    rd(REG_IRQMASK, 32'h1, "mask_unchanged");

    // Authentication flags and mask behaviour
    pulse(3, 1);
    pulse(4, 1);
    repeat (3) @(negedge clk);
    rd(REG_STATUS, 32'h0000_5507, "status_auth_flags");
    wr(REG_IRQMASK, 32'h0);
    chk("irq_masked_off", 32'(irq), 32'd0);
    wr(REG_IRQMASK, 32'h4);
    chk("irq_len_inv", 32'(irq), 32'd1);
    wr(REG_STATUS, 32'hF);
    chk("irq_all_cleared", 32'(irq), 32'd0);
    rd(REG_STATUS, 32'h0000_5500, "status_all_cleared");

    // Error-code log
`ifdef RMAP_STATUS_ERRLOG_EN
    rd(REG_ERRLOG, 32'h0000_010A, "errlog_drain0");
    rd(REG_ERRLOG, 32'h0000_0133, "errlog_drain1");
    rd(REG_ERRLOG, 32'h0000_0144, "errlog_drain2");
    rd(REG_ERRLOG, 32'h0000_0155, "errlog_drain3");
    rd(REG_ERRLOG, 32'h0000_0000, "errlog_empty");
`else
    rd(REG_ERRLOG, 32'h0000_0000, "errlog_absent");
`endif
    wr(REG_IRQMASK, 32'h8);
    for (int i = 1; i <= 5; i++) pulseErr(8'(i));
    repeat (3) @(negedge clk);
`ifdef RMAP_STATUS_ERRLOG_EN
    rd(REG_STATUS, 32'h0000_0509, "status_log_ovf");
    chk("irq_log_ovf", 32'(irq), 32'd1);
    rd(REG_ERRLOG, 32'h0000_0101, "errlog_pop1");
    rd(REG_ERRLOG, 32'h0000_0102, "errlog_pop2");
    rd(REG_ERRLOG, 32'h0000_0103, "errlog_pop3");
    rd(REG_ERRLOG, 32'h0000_0104, "errlog_pop4");
    rd(REG_ERRLOG, 32'h0000_0000, "errlog_empty_after");
`else
    rd(REG_STATUS, 32'h0000_0501, "status_no_log_ovf");
    chk("irq_no_log_ovf", 32'(irq), 32'd0);
`endif

    // Reset in the middle of an access; rmw held high across reset release
    @(negedge clk);
    bus.regReq = 1'b1; bus.regWe = 1'b1; bus.regAddr = REG_CONFIG; bus.regWdata = 32'h0000_1234;
    rmwDataIndication = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus.regReq = 1'b0;
    #1;
    chk("midrst_ack", 32'(bus.regAck), 32'd0);
    chk("midrst_configKey", 32'(configKey), 32'h20);
    chk("midrst_logicalAddress", 32'(logicalAddress), 32'hFE);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    rmwDataIndication = 1'b0;
    repeat (2) @(negedge clk);
    rd(REG_CONFIG, 32'h0000_FE20, "post_rst_config");
    rd(REG_IRQMASK, 32'h0, "post_rst_mask");
    rd(REG_STATUS, 32'h0, "post_rst_status");
    rd(REG_WRCNT, 32'd0, "post_rst_wrcnt");
    rd(REG_RMWCNT, 32'd1, "post_rst_rmw_high_at_release");
    chk("post_rst_irq", 32'(irq), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
